// File: rtl/stg_ia_if.sv
// Bundle between the instruction-address stage and its neighbours: redirect/stall/halt
// requests in, pc/memory-address/valid/flush/halted out.
`ifndef SIZE_ADDR
`define SIZE_ADDR 32
`endif

interface stg_ia_if;
    logic                   iw_stall;
    logic                   iw_branch_valid;
    logic [`SIZE_ADDR-1:0]  iw_branch_pc;
    logic                   iw_halt;
    logic [`SIZE_ADDR-1:0]  ow_mem_addr;
    logic [`SIZE_ADDR-1:0]  ow_pc;
    logic                   ow_ia_valid;
    logic                   ow_flush;
    logic                   ow_halted;

    // The pipeline/testbench side drives requests and observes the stage outputs.
    modport master (
        output iw_stall, iw_branch_valid, iw_branch_pc, iw_halt,
        input  ow_mem_addr, ow_pc, ow_ia_valid, ow_flush, ow_halted
    );

    modport slave (
        input  iw_stall, iw_branch_valid, iw_branch_pc, iw_halt,
        output ow_mem_addr, ow_pc, ow_ia_valid, ow_flush, ow_halted
    );
endinterface

// File: rtl/stg_ia.sv
// Instruction-address stage: owns the program counter, drives imem port 0 and
// sequences boot, advance, stall bubbles, branch redirect with flush, and halt.
`ifndef SIZE_ADDR
`define SIZE_ADDR 32
`endif

module stg_ia #(
    parameter logic [`SIZE_ADDR-1:0] RESET_PC      = '0,
    parameter int                    INCR          = 1,
    parameter int                    FLUSH_BUBBLES = 1
) (
    input  logic     iw_clk,
    input  logic     iw_rst,
    stg_ia_if.slave  ia
);
    localparam int W = `SIZE_ADDR;

    localparam logic [2:0] S_BOOT  = 3'd0;
    localparam logic [2:0] S_RUN   = 3'd1;
    localparam logic [2:0] S_STALL = 3'd2;
    localparam logic [2:0] S_REDIR = 3'd3;
    localparam logic [2:0] S_HALT  = 3'd4;

    localparam logic [W-1:0] PC_STEP     = W'(INCR);
    localparam logic [1:0]   BUBBLE_LOAD = 2'(FLUSH_BUBBLES - 1);

    logic [2:0]   state;
    logic [W-1:0] pc;
    logic         valid;
    logic         flush;
    logic         halted;
    logic [1:0]   bubble_cnt;

    // NOTE: every register here is reset asynchronously and updated with <= only, so all
    // outputs come straight from flops and readers in the same edge see pre-edge values.
    always_ff @(posedge iw_clk or posedge iw_rst) begin
        if (iw_rst) begin
            state      <= S_BOOT;
            pc         <= RESET_PC;
            valid      <= 1'b0;
            flush      <= 1'b0;
            halted     <= 1'b0;
            bubble_cnt <= 2'd0;
        end else begin
            case (state)
                S_BOOT: begin
                    state <= S_RUN;
                    valid <= 1'b1;
                end
                // Priority: branch > halt > stall > advance.
                S_RUN, S_STALL: begin
                    if (ia.iw_branch_valid) begin
                        state      <= S_REDIR;
                        pc         <= ia.iw_branch_pc;
                        valid      <= 1'b0;
                        flush      <= 1'b1;
                        bubble_cnt <= BUBBLE_LOAD;
                    end else if (ia.iw_halt) begin
                        state  <= S_HALT;
                        valid  <= 1'b0;
                        halted <= 1'b1;
                    end else if (ia.iw_stall) begin
                        state <= S_STALL;
                        valid <= 1'b0;
                    end else begin
                        // Leaving a stall reissues the held pc instead of skipping it.
                        if (state == S_RUN) pc <= pc + PC_STEP;
                        state <= S_RUN;
                        valid <= 1'b1;
                    end
                end
                S_REDIR: begin
                    if (ia.iw_branch_valid) begin
                        pc         <= ia.iw_branch_pc;
                        bubble_cnt <= BUBBLE_LOAD;
                    end else if (bubble_cnt == 2'd0) begin
                        state <= S_RUN;
                        valid <= 1'b1;
                        flush <= 1'b0;
                    end else begin
                        bubble_cnt <= bubble_cnt - 2'd1;
                    end
                end
                S_HALT: begin
                    if (ia.iw_branch_valid) begin
                        state      <= S_REDIR;
                        pc         <= ia.iw_branch_pc;
                        flush      <= 1'b1;
                        halted     <= 1'b0;
                        bubble_cnt <= BUBBLE_LOAD;
                    end
                end
                default: state <= S_BOOT;
            endcase
        end
    end

    // Address follows pc even while invalid; reads during bubbles are simply discarded.
    assign ia.ow_mem_addr = pc;
    assign ia.ow_pc       = pc;
    assign ia.ow_ia_valid = valid;
    assign ia.ow_flush    = flush;
    assign ia.ow_halted   = halted;
endmodule

// File: tb/tb_stg_ia.sv
// Bench for stg_ia: two instances (1 and 3 flush bubbles) share directed stimulus and are
// compared every cycle against a behavioural model, plus literal per-step expectations.
`ifndef SIZE_ADDR
`define SIZE_ADDR 32
`endif

module tb_stg_ia;
    localparam int W = `SIZE_ADDR;
    localparam logic [W-1:0] RST_PC = W'('h10);

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic         stall = 1'b0, br = 1'b0, halt = 1'b0;
    logic [W-1:0] bpc = '0;
    bit           en = 1'b0;
    int           n_pass = 0, n_total = 0;

    stg_ia_if bus1 ();
    stg_ia_if bus3 ();
    assign bus1.iw_stall = stall;  assign bus1.iw_branch_valid = br;
    assign bus1.iw_halt  = halt;   assign bus1.iw_branch_pc    = bpc;
    assign bus3.iw_stall = stall;  assign bus3.iw_branch_valid = br;
    assign bus3.iw_halt  = halt;   assign bus3.iw_branch_pc    = bpc;

    stg_ia #(.RESET_PC(RST_PC), .INCR(1), .FLUSH_BUBBLES(1)) dut1 (.iw_clk(clk), .iw_rst(rst), .ia(bus1));
    stg_ia #(.RESET_PC(RST_PC), .INCR(1), .FLUSH_BUBBLES(3)) dut3 (.iw_clk(clk), .iw_rst(rst), .ia(bus3));

    // Model: "running" is simply valid=1; a stalled stage is valid=0 with no flush/halt.
    typedef struct {
        logic [W-1:0] pc;
        bit valid, flush, halted, booted;
        int left;   // flush cycles still to show after the current one
    } model_t;

    model_t m1, m3;

    function automatic model_t m_reset();
        model_t m;
        m.pc = RST_PC; m.valid = 0; m.flush = 0; m.halted = 0; m.booted = 0; m.left = 0;
        return m;
    endfunction

    function automatic model_t m_redirect(model_t m, int fb, logic [W-1:0] t);
        m.pc = t; m.valid = 0; m.flush = 1; m.halted = 0; m.left = fb - 1;
        return m;
    endfunction

    function automatic model_t m_step(model_t m, int fb, bit s, bit b, bit h, logic [W-1:0] t);
        if (!m.booted) begin
            m.booted = 1; m.valid = 1;
        end else if (m.flush) begin
            if (b) m = m_redirect(m, fb, t);
            else if (m.left == 0) begin m.flush = 0; m.valid = 1; end
            else m.left--;
        end else if (m.halted) begin
            if (b) m = m_redirect(m, fb, t);
        end else if (b) begin
            m = m_redirect(m, fb, t);
        end else if (h) begin
            m.halted = 1; m.valid = 0;
        end else if (s) begin
            m.valid = 0;
        end else begin
            if (m.valid) m.pc = m.pc + 1'b1;
            m.valid = 1;
        end
        return m;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m1 = m_reset();
            m3 = m_reset();
        end else begin
            m1 = m_step(m1, 1, stall, br, halt, bpc);
            m3 = m_step(m3, 3, stall, br, halt, bpc);
        end
    end

    task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, got, exp);
    endtask

    always @(negedge clk) begin
        if (en) begin
            check("model_fb1", {bus1.ow_pc, bus1.ow_mem_addr, bus1.ow_ia_valid, bus1.ow_flush, bus1.ow_halted},
                               {m1.pc, m1.pc, m1.valid, m1.flush, m1.halted});
            check("model_fb3", {bus3.ow_pc, bus3.ow_mem_addr, bus3.ow_ia_valid, bus3.ow_flush, bus3.ow_halted},
                               {m3.pc, m3.pc, m3.valid, m3.flush, m3.halted});
        end
    end

    task automatic exp1(input string n, input logic [W-1:0] pc, input bit v, input bit f, input bit h);
        check(n, {bus1.ow_pc, bus1.ow_ia_valid, bus1.ow_flush, bus1.ow_halted}, {pc, v, f, h});
    endtask

    task automatic exp3(input string n, input logic [W-1:0] pc, input bit v, input bit f, input bit h);
        check(n, {bus3.ow_pc, bus3.ow_ia_valid, bus3.ow_flush, bus3.ow_halted}, {pc, v, f, h});
    endtask

    // Present inputs for one edge, then release them so branch is a one-cycle pulse.
    task automatic cyc(input bit s, input bit b, input bit h, input logic [W-1:0] t);
        stall = s; br = b; halt = h; bpc = t;
        @(posedge clk);
        #1;
        stall = 0; br = 0; halt = 0;
    endtask

    initial begin
        #1 rst = 1'b1;
        #1 en = 1'b1;
        exp1("reset_fb1", W'('h10), 0, 0, 0);
        exp3("reset_fb3", W'('h10), 0, 0, 0);
        #10 rst = 1'b0;
        #1 exp1("boot_idle", W'('h10), 0, 0, 0);

        cyc(0, 0, 0, '0); exp1("first_valid", W'('h10), 1, 0, 0);
        cyc(0, 0, 0, '0); exp1("run_11", W'('h11), 1, 0, 0);
        cyc(0, 0, 0, '0); exp1("run_12", W'('h12), 1, 0, 0);
        for (int i = 0; i < 3; i++) begin
            cyc(1, 0, 0, '0); exp1("stall_hold", W'('h12), 0, 0, 0);
        end
        cyc(0, 0, 0, '0); exp1("stall_reissue", W'('h12), 1, 0, 0);
        cyc(0, 0, 0, '0); exp1("after_stall", W'('h13), 1, 0, 0);

        cyc(0, 1, 0, W'('h40)); exp1("br_flush_fb1", W'('h40), 0, 1, 0); exp3("br_flush1_fb3", W'('h40), 0, 1, 0);
        cyc(0, 0, 0, '0);       exp1("br_target_fb1", W'('h40), 1, 0, 0); exp3("br_flush2_fb3", W'('h40), 0, 1, 0);
        cyc(0, 0, 0, '0);       exp1("br_next_fb1", W'('h41), 1, 0, 0);   exp3("br_flush3_fb3", W'('h40), 0, 1, 0);
        cyc(0, 0, 0, '0);       exp3("br_target_fb3", W'('h40), 1, 0, 0);
        cyc(0, 0, 0, '0);       exp3("br_next_fb3", W'('h41), 1, 0, 0);

        cyc(0, 1, 0, W'('h60)); exp3("br60_fb3", W'('h60), 0, 1, 0);
        cyc(0, 1, 0, W'('h80)); exp1("rebr_fb1", W'('h80), 0, 1, 0); exp3("rebr_fb3", W'('h80), 0, 1, 0);
        cyc(0, 0, 0, '0);       exp1("rebr_tgt_fb1", W'('h80), 1, 0, 0); exp3("rebr_f1_fb3", W'('h80), 0, 1, 0);
        cyc(0, 0, 0, '0);       exp3("rebr_f2_fb3", W'('h80), 0, 1, 0);
        cyc(0, 0, 0, '0);       exp3("rebr_tgt_fb3", W'('h80), 1, 0, 0); exp1("rebr_run_fb1", W'('h82), 1, 0, 0);

        cyc(1, 1, 1, W'('h50)); exp1("prio_branch", W'('h50), 0, 1, 0);
        cyc(0, 0, 0, '0);       exp1("prio_target", W'('h50), 1, 0, 0);

        cyc(0, 1, 0, W'('h20)); cyc(0, 0, 0, '0); exp1("at_20", W'('h20), 1, 0, 0);
        cyc(1, 0, 1, '0);       exp1("halt_enter", W'('h20), 0, 0, 1);
        for (int i = 0; i < 5; i++) begin
            cyc(i[0], 0, i == 2, '0); exp1("halt_sticky", W'('h20), 0, 0, 1);
        end
        cyc(0, 1, 0, '0);       exp1("halt_exit", '0, 0, 1, 0);
        cyc(0, 0, 0, '0);       exp1("halt_target", '0, 1, 0, 0);

        cyc(0, 1, 0, '1); cyc(0, 0, 0, '0); exp1("at_ones", '1, 1, 0, 0);
        cyc(0, 0, 0, '0);       exp1("wrap_zero", '0, 1, 0, 0);

        cyc(1, 0, 0, '0);       exp1("stall_zero", '0, 0, 0, 0);
        cyc(0, 1, 0, W'('h90)); exp1("stall_branch", W'('h90), 0, 1, 0);
        cyc(0, 0, 0, '0);       exp1("stall_br_tgt", W'('h90), 1, 0, 0);

        cyc(0, 1, 0, W'('h70)); exp1("redir_70", W'('h70), 0, 1, 0);
        #2 rst = 1'b1;
        #1 exp1("async_rst_fb1", W'('h10), 0, 0, 0);
        exp3("async_rst_fb3", W'('h10), 0, 0, 0);
        @(negedge clk);
        #3 rst = 1'b0;
        @(posedge clk); #1 exp1("rst_first_valid", W'('h10), 1, 0, 0);
        cyc(0, 0, 0, '0);       exp1("rst_run_11", W'('h11), 1, 0, 0);

        repeat (2) @(negedge clk);
        #1 $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
